axi_sram_slave: RTL and testbench

//  AXI3 responder (slave) backed by an internal word-addressed SRAM array.

---
 rtl/axi_sram_slave_if.sv | 99 +++++++++
 rtl/axi_sram_slave.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
// Purpose : AXI3 bus bundle between a CPU-side master and axi_sram_slave.
//           Carries the five AXI3 channels (AR, R, AW, W, B); clock and reset
//           are kept as plain ports on the modules that use this bundle.
// Modports:
//   slave  - responder view: address/write-data/ready-for-response inputs,
//            address-ready / read-data / write-response outputs.
//   master - requester view: the exact mirror of slave.
// Signals :
//   AR  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
//       arvalid, arready
//   R   rid, rdata, rresp, rlast, rvalid, rready
//   AW  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
//       awvalid, awready
//   W   wid, wdata, wstrb, wlast, wvalid, wready
//   B   bid, bresp, bvalid, bready
// ---------------------------------------------------------------------------
interface axi_sram_slave_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Read address channel
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    // Read data channel
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    // Write address channel
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    // Write data channel
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    // Write response channel
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// Purpose : AXI3 responder backed by an internal word-addressed SRAM. Serves
//           instruction fetches, loads and stores from a CPU master port.
//           Read and write channels are independent FSMs, each handling one
//           burst at a time (single-beat and multi-beat FIXED/INCR; WRAP is
//           treated as INCR). Writes honour byte strobes; reads return the
//           full word. A same-cycle read and write of one word returns the
//           old data.
// Ports   :
//   aclk    in  clock, all logic on the rising edge
//   areset  in  synchronous reset, active-high
//   bus     axi_sram_slave_if.slave - AR/R/AW/W/B channels
// Parameters:
//   ID_W, ADDR_W, DATA_W (must be 32), MEM_DEPTH_LOG2 (array depth in words)
// Configuration:
//   AXI_SRAM_SLAVE_RANGE_ERR_EN - when defined, beats addressed at or above
//   4<<MEM_DEPTH_LOG2 get SLVERR: reads return zero data, writes are dropped
//   and flag the burst's bresp. When undefined, high address bits are
//   ignored (addresses wrap modulo the array size) and responses are OKAY.
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int ID_W           = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_DEPTH_LOG2 = 12
) (
    input logic             aclk,
    input logic             areset,
    axi_sram_slave_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // -----------------------------------------------------------------------
    // Address helpers
    // -----------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        if (burst == BURST_FIXED) begin
            return a;
        end
        return a + (ADDR_W'(1) << size);
    endfunction

    function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(
        input logic [ADDR_W-1:0] a
    );
        return a[MEM_DEPTH_LOG2+1:2];
    endfunction

`ifdef AXI_SRAM_SLAVE_RANGE_ERR_EN
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return |a[ADDR_W-1:MEM_DEPTH_LOG2+2];
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // -----------------------------------------------------------------------
    // Read channel state
    // -----------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [3:0]        r_cnt;
    logic              rvalid_q;
    logic              rlast_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    // Fetch control: which address (if any) loads the read data register
    // on the coming edge. The first beat is fetched straight from araddr so
    // rvalid rises the cycle after the AR handshake.
    logic              rd_load;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_load = 1'b0;
        rd_addr = r_addr;
        if (r_state == R_IDLE) begin
            rd_load = bus.arvalid;
            rd_addr = bus.araddr;
        end else if (bus.rready && !rlast_q) begin
            rd_load = 1'b1;
            rd_addr = next_addr(r_addr, r_size, r_burst);
        end
    end

    assign rd_word = mem[word_idx(rd_addr)];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and same-edge updates never race.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (rd_load) begin
                r_addr  <= rd_addr;
                rdata_q <= rd_word;
                rresp_q <= RESP_OKAY;
`ifdef AXI_SRAM_SLAVE_RANGE_ERR_EN
                if (out_of_range(rd_addr)) begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end
`endif
            end

            if (r_state == R_IDLE) begin
                if (bus.arvalid) begin
                    r_state  <= R_BURST;
                    r_id     <= bus.arid;
                    r_len    <= bus.arlen;
                    r_size   <= bus.arsize;
                    r_burst  <= bus.arburst;
                    r_cnt    <= '0;
                    rvalid_q <= 1'b1;
                    rlast_q  <= (bus.arlen == 4'd0);
                end
            end else if (bus.rready) begin
                if (rlast_q) begin
                    r_state  <= R_IDLE;
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + 4'd1;
                    rlast_q <= ((r_cnt + 4'd1) == r_len);
                end
            end
        end
    end

    assign bus.arready = (r_state == R_IDLE) && !areset;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rid     = r_id;

    // -----------------------------------------------------------------------
    // Write channel state
    // -----------------------------------------------------------------------
    logic [1:0]        w_state;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err;
    logic [1:0]        bresp_q;

    logic wr_beat;   // W handshake this cycle
    logic wr_drop;   // beat addressed outside the array

    assign wr_beat = (w_state == W_DATA) && bus.wvalid && !areset;

`ifdef AXI_SRAM_SLAVE_RANGE_ERR_EN
    assign wr_drop = out_of_range(w_addr);
`else
    assign wr_drop = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.awvalid) begin
                        w_state <= W_DATA;
                        w_id    <= bus.awid;
                        w_addr  <= bus.awaddr;
                        w_size  <= bus.awsize;
                        w_burst <= bus.awburst;
                        w_err   <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (bus.wvalid) begin
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_err  <= w_err | wr_drop;
                        // The burst ends on wlast regardless of awlen.
                        if (bus.wlast) begin
                            w_state <= W_RESP;
                            bresp_q <= (w_err || wr_drop) ? RESP_SLVERR
                                                          : RESP_OKAY;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the SRAM array has no reset; its contents survive areset and
    // leaving it out of the reset branch keeps it mappable to a RAM macro.
    always_ff @(posedge aclk) begin
        if (wr_beat && !wr_drop) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.wstrb[i]) begin
                    mem[word_idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.awready = (w_state == W_IDLE) && !areset;
    assign bus.wready  = (w_state == W_DATA) && !areset;
    assign bus.bvalid  = (w_state == W_RESP) && !areset;
    assign bus.bid     = w_id;
    assign bus.bresp   = bresp_q;

    // Inputs that carry no meaning for this responder; awlen is unused
    // because the write burst length is taken from wlast.
    logic unused_inputs;
    assign unused_inputs = ^{bus.wid, bus.awlen,
                             bus.arlock, bus.arcache, bus.arprot,
                             bus.awlock, bus.awcache, bus.awprot};

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Purpose : self-checking bench for axi_sram_slave. Directed cases cover
//           single writes/reads, INCR/FIXED bursts, byte strobes, back-
//           pressure on R and B, reset mid-burst, concurrent AR/AW,
//           read-before-write and the out-of-range address; a randomized
//           phase then mixes bursts inside a prefilled window. Expected
//           values come from a word array model updated per beat address
//           computed arithmetically from start, size and burst type.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

    localparam int ID_W           = 4;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int MEM_DEPTH_LOG2 = 12;
    localparam int DEPTH          = 1 << MEM_DEPTH_LOG2;

`ifdef AXI_SRAM_SLAVE_RANGE_ERR_EN
    localparam bit RANGE_ERR = 1'b1;
`else
    localparam bit RANGE_ERR = 1'b0;
`endif

    logic aclk = 1'b0;
    logic areset;

    always #5 aclk = ~aclk;

    axi_sram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_sram_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [0:DEPTH-1];

    function automatic bit oor(input logic [31:0] a);
        return a >= (32'd4 << MEM_DEPTH_LOG2);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start,
                                              input int k,
                                              input logic [2:0] size,
                                              input logic [1:0] burst);
        if (burst == 2'b00) return start;
        return start + 32'(k) * (32'd1 << size);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int idx;
        if (RANGE_ERR && oor(a)) return;
        idx = int'((a >> 2) % DEPTH);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic ref_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        if (RANGE_ERR && oor(a)) begin
            d = 32'h0;
            resp = 2'b10;
        end else begin
            d = ref_mem[int'((a >> 2) % DEPTH)];
            resp = 2'b00;
        end
    endtask

    // ------------------------------------------------------------------
    // Bus helpers: inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_req(input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [2:0] size,
                          input logic [1:0] burst);
        int n = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(len);
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        while (!bus.awready && n < 50) begin tick(); n++; end
        check("awready", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                          input bit last);
        int n = 0;
        bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin tick(); n++; end
        check("wready", bus.wready, 1);
        tick();
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic b_check(input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        bus.bready = 1'b1;
        while (!bus.bvalid && n < 50) begin tick(); n++; end
        check("bvalid", bus.bvalid, 1);
        check("bid", bus.bid, id);
        check("bresp", bus.bresp, resp);
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input int len, input logic [2:0] size,
                               input logic [1:0] burst, input bit rnd_strb);
        bit err = 1'b0;
        aw_req(id, addr, len, size, burst);
        for (int k = 0; k <= len; k++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            a = beat_addr(addr, k, size, burst);
            d = $urandom;
            s = rnd_strb ? 4'($urandom) : 4'hF;
            w_beat(d, s, k == len);
            if (RANGE_ERR && oor(a)) err = 1'b1;
            ref_write(a, d, s);
        end
        b_check(id, err ? 2'b10 : 2'b00);
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [2:0] size,
                          input logic [1:0] burst);
        int n = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = 4'(len);
        bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin tick(); n++; end
        check("arready", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
        check("r_latency", bus.rvalid, 1);
    endtask

    // Collects a whole read burst; each beat must be valid immediately
    // after the previous handshake. stall_at drops rready for 3 cycles
    // before that beat (out of range = no stall).
    task automatic r_burst(input logic [3:0] id, input logic [31:0] addr,
                           input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_at);
        bus.rready = 1'b1;
        for (int k = 0; k <= len; k++) begin
            logic [31:0] ed;
            logic [1:0]  er;
            ref_read(beat_addr(addr, k, size, burst), ed, er);
            check("rvalid", bus.rvalid, 1);
            check("rid", bus.rid, id);
            check("rdata", bus.rdata, ed);
            check("rresp", bus.rresp, er);
            check("rlast", bus.rlast, k == len);
            if (k == stall_at) begin
                bus.rready = 1'b0;
                repeat (3) begin
                    tick();
                    check("stall_rvalid", bus.rvalid, 1);
                    check("stall_rdata", bus.rdata, ed);
                    check("stall_rlast", bus.rlast, k == len);
                end
                bus.rready = 1'b1;
            end
            tick();
        end
        bus.rready = 1'b0;
        check("r_done_rvalid", bus.rvalid, 0);
        check("r_done_arready", bus.arready, 1);
    endtask

    task automatic read_check(input logic [3:0] id, input logic [31:0] addr,
                              input int len, input logic [2:0] size,
                              input logic [1:0] burst, input int stall_at);
        ar_req(id, addr, len, size, burst);
        r_burst(id, addr, len, size, burst, stall_at);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] d_old, d_new, ed;
        logic [1:0]  er;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        areset = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arlock = '0; bus.arcache = '0; bus.arprot = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.awburst = '0; bus.awlock = '0; bus.awcache = '0; bus.awprot = '0;
        bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_arready", bus.arready, 0);
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rid", bus.rid, 0);
        check("rst_bid", bus.bid, 0);
        check("rst_bresp", bus.bresp, 0);
        areset = 1'b0;
        tick();
        check("idle_arready", bus.arready, 1);
        check("idle_awready", bus.awready, 1);

        // W before AW is not accepted
        bus.wvalid = 1'b1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
        bus.wlast = 1'b1;
        repeat (2) begin
            check("early_wready", bus.wready, 0);
            tick();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;

        // T1 single write then single read
        aw_req(4'd3, 32'h10, 0, 3'd2, 2'b01);
        w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
        ref_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        b_check(4'd3, 2'b00);
        read_check(4'd5, 32'h10, 0, 3'd2, 2'b01, -1);

        // T2 INCR 4-beat write, back-to-back read
        aw_req(4'd1, 32'h100, 3, 3'd2, 2'b01);
        for (int i = 1; i <= 4; i++) begin
            w_beat(32'(i), 4'hF, i == 4);
            ref_write(32'h100 + 32'(4 * (i - 1)), 32'(i), 4'hF);
        end
        b_check(4'd1, 2'b00);
        read_check(4'd2, 32'h100, 3, 3'd2, 2'b01, -1);

        // T3 byte strobes, FIXED burst
        aw_req(4'd0, 32'h0, 0, 3'd2, 2'b01);
        w_beat(32'h0, 4'hF, 1'b1);
        ref_write(32'h0, 32'h0, 4'hF);
        b_check(4'd0, 2'b00);
        aw_req(4'd0, 32'h0, 0, 3'd2, 2'b01);
        w_beat(32'hAABB_CCDD, 4'b0101, 1'b1);
        ref_write(32'h0, 32'hAABB_CCDD, 4'b0101);
        b_check(4'd0, 2'b00);
        check("strb_model", ref_mem[0], 32'h00BB_00DD);
        read_check(4'd4, 32'h0, 0, 3'd2, 2'b01, -1);
        aw_req(4'd6, 32'h20, 1, 3'd2, 2'b00);
        w_beat(32'd7, 4'hF, 1'b0);
        w_beat(32'd9, 4'hF, 1'b1);
        ref_write(32'h20, 32'd7, 4'hF);
        ref_write(32'h20, 32'd9, 4'hF);
        b_check(4'd6, 2'b00);
        read_check(4'd6, 32'h20, 0, 3'd2, 2'b01, -1);

        // T4 R and B back-pressure
        read_check(4'd7, 32'h100, 3, 3'd2, 2'b01, 1);
        aw_req(4'd8, 32'h40, 0, 3'd2, 2'b01);
        w_beat(32'hCAFE_F00D, 4'hF, 1'b1);
        ref_write(32'h40, 32'hCAFE_F00D, 4'hF);
        repeat (4) begin
            check("bhold_bvalid", bus.bvalid, 1);
            check("bhold_awready", bus.awready, 0);
            tick();
        end
        b_check(4'd8, 2'b00);

        // T5 reset during beat 2 of a 4-beat read
        ar_req(4'd9, 32'h100, 3, 3'd2, 2'b01);
        bus.rready = 1'b1;
        tick();
        check("t5_beat2_valid", bus.rvalid, 1);
        areset = 1'b1;
        tick();
        check("t5_rst_rvalid", bus.rvalid, 0);
        check("t5_rst_rlast", bus.rlast, 0);
        check("t5_rst_rdata", bus.rdata, 0);
        check("t5_rst_arready", bus.arready, 0);
        areset = 1'b0;
        bus.rready = 1'b0;
        tick();
        check("t5_arready", bus.arready, 1);
        read_check(4'd9, 32'h100, 3, 3'd2, 2'b01, -1);
        read_check(4'd9, 32'h10, 0, 3'd2, 2'b01, -1);

        // Prefill window words 64..127 for the later tests
        for (int i = 0; i < 4; i++)
            write_burst(4'(i), 32'h100 + 32'(64 * i), 15, 3'd2, 2'b01, 1'b0);

        // Simultaneous AR and AW accepted in the same cycle
        bus.arid = 4'd10; bus.araddr = 32'h100; bus.arlen = 4'd0;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        bus.awid = 4'd11; bus.awaddr = 32'h104; bus.awlen = 4'd0;
        bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        check("dual_arready", bus.arready, 1);
        check("dual_awready", bus.awready, 1);
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        check("dual_rvalid", bus.rvalid, 1);
        check("dual_wready", bus.wready, 1);
        ref_read(32'h100, ed, er);
        check("dual_rdata", bus.rdata, ed);
        d_new = $urandom;
        bus.rready = 1'b1;
        bus.wdata = d_new; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        bus.wvalid = 1'b1;
        tick();
        bus.rready = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        ref_write(32'h104, d_new, 4'hF);
        check("dual_r_done", bus.rvalid, 0);
        b_check(4'd11, 2'b00);
        read_check(4'd10, 32'h104, 0, 3'd2, 2'b01, -1);

        // Read-before-write on the same word in the same cycle
        d_old = ref_mem[112];
        d_new = ~d_old;
        aw_req(4'd2, 32'h1C0, 0, 3'd2, 2'b01);
        bus.arid = 4'd6; bus.araddr = 32'h1C0; bus.arlen = 4'd0;
        bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        bus.wdata = d_new; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        bus.wvalid = 1'b1;
        check("rbw_arready", bus.arready, 1);
        check("rbw_wready", bus.wready, 1);
        tick();
        bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        check("rbw_rvalid", bus.rvalid, 1);
        check("rbw_old_data", bus.rdata, d_old);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        ref_write(32'h1C0, d_new, 4'hF);
        b_check(4'd2, 2'b00);
        read_check(4'd6, 32'h1C0, 0, 3'd2, 2'b01, -1);

        // T6 out-of-range read and write
        read_check(4'd12, 32'h4000, 0, 3'd2, 2'b01, -1);
        write_burst(4'd13, 32'h8, 0, 3'd2, 2'b01, 1'b0);
        write_burst(4'd14, 32'h4008, 0, 3'd2, 2'b01, 1'b0);
        read_check(4'd12, 32'h8, 0, 3'd2, 2'b01, -1);
        read_check(4'd12, 32'h4008, 0, 3'd2, 2'b01, -1);

        // Randomized bursts inside the prefilled window
        for (int it = 0; it < 40; it++) begin
            int          len, span;
            logic [2:0]  size;
            logic [1:0]  burst;
            logic [31:0] addr;
            logic [3:0]  id;
            len   = $urandom_range(0, 15);
            size  = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 2));
            id    = 4'($urandom);
            span  = len * (1 << size);
            addr  = 32'h100 + 32'($urandom_range(0, 255 - span));
            addr  = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 1) == 0)
                write_burst(id, addr, len, size, burst, 1'b1);
            else
                read_check(id, addr, len, size, burst,
                           $urandom_range(0, len + 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
